// File: rtl/rcv_frame_assembler.sv
// rcv_frame_assembler: assembles sync/cmd/len/payload/checksum frames from the UART byte stream.
module rcv_frame_assembler #(
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         MAX_LEN = 16,
  parameter int         TIMEOUT = 2048
) (
  input  logic                       clk,
  input  logic                       gl_reset,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_ready,
  input  logic                       rx_error,
  output logic                       frame_valid,
  input  logic                       frame_ack,
  output logic [7:0]                 cmd_out,
  output logic [$clog2(MAX_LEN):0]   len_out,
  input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
  output logic [7:0]                 rd_data,
  output logic                       frame_err,
  output logic [1:0]                 err_code,
  output logic                       overrun
);
  localparam int AW = $clog2(MAX_LEN);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  typedef enum logic [2:0] {IDLE, CMD, LEN, PAYLOAD, CSUM, HOLD} state_t;
  state_t state, state_n;
  logic rx_ready_q, rx_error_q, err_evt, byte_evt, in_frame, len_bad, last, abort;
  logic [1:0] code_n;
  logic [7:0] sum, cmd_r;
  logic [LW-1:0] len_r;
  logic [AW-1:0] wr_ptr;
  logic [TW-1:0] cnt;
  logic [7:0] pay_mem [MAX_LEN];
  // a parity error in the same cycle as a good byte wins
  assign err_evt = rx_error & ~rx_error_q;
  assign byte_evt = rx_ready & ~rx_ready_q & ~err_evt;
  assign in_frame = state inside {CMD, LEN, PAYLOAD, CSUM};
  assign len_bad = {1'b0, rx_data} > 9'(MAX_LEN);
  assign last = {1'b0, wr_ptr} == len_r - LW'(1);
  assign frame_valid = state == HOLD;
  assign rd_data = {1'b0, rd_addr} < len_out ? pay_mem[rd_addr] : 8'h00;
  always_comb begin
    state_n = state;
    abort = 1'b0;
    code_n = err_code;
    case (state)
      IDLE: if (byte_evt && rx_data == SYNC) state_n = CMD;
      CMD: if (byte_evt) state_n = LEN;
      LEN: if (byte_evt) begin
        abort = len_bad;
        code_n = 2'b10;
        state_n = rx_data == 8'h00 ? CSUM : PAYLOAD;
      end
      PAYLOAD: if (byte_evt && last) state_n = CSUM;
      CSUM: if (byte_evt) begin
        abort = rx_data != sum;
        code_n = 2'b11;
        state_n = HOLD;
      end
      HOLD: if (frame_ack) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (in_frame && err_evt) begin
      abort = 1'b1;
      code_n = 2'b01;
    end else if (in_frame && !byte_evt && cnt == TW'(TIMEOUT - 1)) begin
      abort = 1'b1;
      code_n = 2'b00;
    end
    if (abort) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge gl_reset) begin
    if (!gl_reset) begin
      state <= IDLE;
      rx_ready_q <= 1'b0;
      rx_error_q <= 1'b0;
      frame_err <= 1'b0;
      err_code <= 2'b00;
      overrun <= 1'b0;
      cnt <= '0;
      sum <= '0;
      wr_ptr <= '0;
      cmd_r <= '0;
      len_r <= '0;
      cmd_out <= '0;
      len_out <= '0;
    end else begin
      state <= state_n;
      rx_ready_q <= rx_ready;
      rx_error_q <= rx_error;
      frame_err <= abort;
      if (abort) err_code <= code_n;
      overrun <= frame_valid & ~frame_ack & (overrun | byte_evt);
      cnt <= (byte_evt || !in_frame) ? '0 : cnt + TW'(1);
      if (byte_evt && state == CMD) begin
        cmd_r <= rx_data;
        sum <= rx_data;
      end
      if (byte_evt && state == LEN) begin
        len_r <= LW'(rx_data);
        sum <= sum + rx_data;
        wr_ptr <= '0;
      end
      if (byte_evt && state == PAYLOAD) begin
        sum <= sum + rx_data;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (byte_evt && state == CSUM && !abort) begin
        cmd_out <= cmd_r;
        len_out <= len_r;
      end
    end
  end
  always_ff @(posedge clk)
    if (byte_evt && state == PAYLOAD) pay_mem[wr_ptr] <= rx_data;
endmodule

// File: tb/tb_rcv_frame_assembler.sv
// tb_rcv_frame_assembler: directed frames with hand-computed expectations for rcv_frame_assembler.
module tb_rcv_frame_assembler;
  localparam int TIMEOUT = 2048;
  logic clk = 1'b0, gl_reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_ready = 1'b0, rx_error = 1'b0, frame_ack = 1'b0;
  logic [3:0] rd_addr = 4'd0;
  logic frame_valid, frame_err, overrun, err_k1;
  logic [7:0] cmd_out, rd_data;
  logic [4:0] len_out;
  logic [1:0] err_code;
  int total = 0, passed = 0;

  rcv_frame_assembler dut (
    .clk(clk), .gl_reset(gl_reset), .rx_data(rx_data), .rx_ready(rx_ready), .rx_error(rx_error),
    .frame_valid(frame_valid), .frame_ack(frame_ack), .cmd_out(cmd_out), .len_out(len_out),
    .rd_addr(rd_addr), .rd_data(rd_data), .frame_err(frame_err), .err_code(err_code), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // one byte: ready high for a cycle, frame_err captured in the cycle after the event
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    err_k1 = frame_err;
    rx_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_err();
    rx_error = 1'b1;
    @(posedge clk); #1;
    err_k1 = frame_err;
    rx_error = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    @(posedge clk); #1;
    frame_ack = 1'b0;
  endtask

  task automatic send_good();
    send(8'hA5); send(8'h03); send(8'h02); send(8'h11); send(8'h22); send(8'h38);
  endtask

  initial begin
    int n;
    #12 chk("rst_valid", 32'(frame_valid), 0);
    chk("rst_err", 32'(frame_err), 0);
    chk("rst_ovr", 32'(overrun), 0);
    chk("rst_code", 32'(err_code), 0);
    chk("rst_cmd", 32'(cmd_out), 0);
    chk("rst_len", 32'(len_out), 0);
    chk("rst_rd", 32'(rd_data), 0);
    @(posedge clk); #1 gl_reset = 1'b1;
    @(posedge clk); #1;

    send_good();
    chk("good_valid", 32'(frame_valid), 1);
    chk("good_cmd", 32'(cmd_out), 32'h03);
    chk("good_len", 32'(len_out), 2);
    rd_addr = 4'd0; #1 chk("good_rd0", 32'(rd_data), 32'h11);
    rd_addr = 4'd1; #1 chk("good_rd1", 32'(rd_data), 32'h22);
    rd_addr = 4'd2; #1 chk("good_rd2", 32'(rd_data), 32'h00);
    ack();
    chk("good_ack", 32'(frame_valid), 0);

    send(8'hA5); send(8'h7F); send(8'h00); send(8'h7F);
    chk("zl_valid", 32'(frame_valid), 1);
    chk("zl_len", 32'(len_out), 0);
    rd_addr = 4'd0; #1 chk("zl_rd0", 32'(rd_data), 0);
    rd_addr = 4'd15; #1 chk("zl_rd15", 32'(rd_data), 0);
    ack();

    send(8'hA5); send(8'h03); send(8'h02); send(8'h11); send(8'h22); send(8'h39);
    chk("cs_err", 32'(err_k1), 1);
    chk("cs_pulse", 32'(frame_err), 0);
    chk("cs_code", 32'(err_code), 3);
    chk("cs_valid", 32'(frame_valid), 0);
    send(8'hA5); send(8'h01); send(8'h00); send(8'h01);
    chk("cs2_valid", 32'(frame_valid), 1);
    chk("cs2_cmd", 32'(cmd_out), 32'h01);
    ack();

    send(8'hA5); send(8'h03); send(8'h11);
    chk("len_err", 32'(err_k1), 1);
    chk("len_code", 32'(err_code), 2);
    chk("len_valid", 32'(frame_valid), 0);

    send(8'hA5); send(8'h03); send(8'h02); send(8'h11);
    send_err();
    chk("par_err", 32'(err_k1), 1);
    chk("par_code", 32'(err_code), 1);
    send_err();
    chk("idle_err", 32'(err_k1), 0);
    chk("idle_code", 32'(err_code), 1);

    send(8'hA5); send(8'h05);
    n = 1;
    while (!frame_err && n < TIMEOUT + 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("tmo_cycles", 32'(n), 32'(TIMEOUT));
    chk("tmo_code", 32'(err_code), 0);
    @(posedge clk); #1;
    send(8'h03); send(8'h00); send(8'h03);
    chk("tmo_ign_err", 32'(err_k1), 0);
    chk("tmo_ign_valid", 32'(frame_valid), 0);

    send_good();
    send(8'h44);
    chk("hold_ovr", 32'(overrun), 1);
    chk("hold_valid", 32'(frame_valid), 1);
    chk("hold_cmd", 32'(cmd_out), 32'h03);
    rd_addr = 4'd0; #1 chk("hold_rd0", 32'(rd_data), 32'h11);
    ack();
    chk("hold_ack_ovr", 32'(overrun), 0);
    chk("hold_ack_valid", 32'(frame_valid), 0);

    send_good();
    rx_data = 8'h44; rx_ready = 1'b1; frame_ack = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0; frame_ack = 1'b0;
    chk("same_ovr", 32'(overrun), 0);
    chk("same_valid", 32'(frame_valid), 0);
    @(posedge clk); #1;

    send(8'hA5); send(8'h03); send(8'h11);
    send(8'hA5); send(8'h03); send(8'h02); send(8'h11);
    gl_reset = 1'b0;
    #2;
    chk("mid_code", 32'(err_code), 0);
    chk("mid_cmd", 32'(cmd_out), 0);
    chk("mid_len", 32'(len_out), 0);
    chk("mid_valid", 32'(frame_valid), 0);
    chk("mid_rd", 32'(rd_data), 0);
    @(posedge clk); #1 gl_reset = 1'b1;
    @(posedge clk); #1;
    send_good();
    chk("post_valid", 32'(frame_valid), 1);
    chk("post_len", 32'(len_out), 2);
    rd_addr = 4'd1; #1 chk("post_rd1", 32'(rd_data), 32'h22);
    ack();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
